// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Divides the system clock down to a pixel-rate enable and walks an
// h/v raster. Sync, blanking and colour are registered one pixel behind
// the counters, so the image memory has a full pixel period to respond
// to pixel_x/pixel_y before rgb is sampled.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        h_sync,
    output logic        v_sync,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic        video_on,
    output logic        frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // True when a counter lies inside an inclusive window (sync pulse decode).
    function automatic logic in_window(input logic [9:0] val,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

    // Colour forced to black outside the visible area.
    function automatic logic [11:0] blank_rgb(input logic [11:0] col,
                                              input logic        active);
        return active ? col : 12'h000;
    endfunction

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_h_cnt;
    logic [9:0]       r_v_cnt;

    logic             r_h_sync_p1;
    logic             r_v_sync_p1;
    logic             r_video_on_p1;
    logic [11:0]      r_rgb_p1;
    logic             r_frame_start_p1;

    logic             w_pix_tick;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_active;

    assign w_pix_tick = (r_div_cnt == DIV_LAST);
    assign w_h_wrap   = (r_h_cnt == H_LAST);
    assign w_v_wrap   = (r_v_cnt == V_LAST);
    assign w_active   = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);

    // Pixel-rate enable: divider counts 0..CLK_DIV-1 and wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_pix_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Raster counters: h advances per pixel, v advances when h wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_pix_tick) begin
            if (w_h_wrap) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // ---- stage p1: outputs decoded from the pre-increment counters ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_sync_p1      <= 1'b1;
            r_v_sync_p1      <= 1'b1;
            r_video_on_p1    <= 1'b0;
            r_rgb_p1         <= '0;
            r_frame_start_p1 <= 1'b0;
        end else begin
            r_frame_start_p1 <= w_pix_tick && w_h_wrap && w_v_wrap;
            if (w_pix_tick) begin
                r_video_on_p1 <= w_active;
                r_rgb_p1      <= blank_rgb(rgb, w_active);
                r_h_sync_p1   <= ~in_window(r_h_cnt, H_SYNC_LO, H_SYNC_HI);
                r_v_sync_p1   <= ~in_window(r_v_cnt, V_SYNC_LO, V_SYNC_HI);
            end
        end
    end

    assign pixel_x     = r_h_cnt;
    assign pixel_y     = r_v_cnt;
    assign h_sync      = r_h_sync_p1;
    assign v_sync      = r_v_sync_p1;
    assign video_on    = r_video_on_p1;
    assign Red         = r_rgb_p1[11:8];
    assign Green       = r_rgb_p1[7:4];
    assign Blue        = r_rgb_p1[3:0];
    assign frame_start = r_frame_start_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: one full-size default instance plus two
// shrunken-raster instances (CLK_DIV=3 and CLK_DIV=1) for frame-level behaviour.
module tb_vga_timing_gen;

    localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVA = 6,  SVF = 1, SVS = 2, SVB = 2;
    localparam int SHT = SHA + SHF + SHS + SHB;   // 23 pixels per line
    localparam int SVT = SVA + SVF + SVS + SVB;   // 11 lines per frame

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d = 1'b1;
    logic        rst_s = 1'b1;
    logic [11:0] rgb_d = 12'h000;
    logic [11:0] rgb_s = 12'h000;

    logic [9:0] d_px, d_py, s3_px, s3_py, s1_px, s1_py;
    logic       d_hs, d_vs, d_von, d_fs;
    logic       s3_hs, s3_vs, s3_von, s3_fs;
    logic       s1_hs, s1_vs, s1_von, s1_fs;
    logic [3:0] d_r, d_g, d_b, s3_r, s3_g, s3_b, s1_r, s1_g, s1_b;

    vga_timing_gen u_def (
        .clk(clk), .rst(rst_d), .rgb(rgb_d),
        .pixel_x(d_px), .pixel_y(d_py), .h_sync(d_hs), .v_sync(d_vs),
        .Red(d_r), .Green(d_g), .Blue(d_b), .video_on(d_von), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) u_s3 (
        .clk(clk), .rst(rst_s), .rgb(rgb_s),
        .pixel_x(s3_px), .pixel_y(s3_py), .h_sync(s3_hs), .v_sync(s3_vs),
        .Red(s3_r), .Green(s3_g), .Blue(s3_b), .video_on(s3_von), .frame_start(s3_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) u_s1 (
        .clk(clk), .rst(rst_s), .rgb(rgb_s),
        .pixel_x(s1_px), .pixel_y(s1_py), .h_sync(s1_hs), .v_sync(s1_vs),
        .Red(s1_r), .Green(s1_g), .Blue(s1_b), .video_on(s1_von), .frame_start(s1_fs)
    );

    typedef struct packed {
        logic [9:0]  px;
        logic [9:0]  py;
        logic        hs;
        logic        vs;
        logic        von;
        logic [11:0] col;
        logic        fs;
    } exp_t;

    typedef struct {
        int          n;      // clocks after reset release
        logic [11:0] rgb;
        exp_t        e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[12];

    // Shrunken-raster reference state: clocks since reset, colour at the last pixel tick.
    int          n3 = 0, n1 = 0;
    logic [11:0] t3 = 12'h000, t1 = 12'h000;

    int fs_cnt, first_fs, second_fs, hs_low, vs_low, first_low;

    function automatic exp_t mk(input int px, input int py, input logic hs, input logic vs,
                                input logic von, input logic [11:0] col, input logic fs);
        exp_t e;
        e.px = 10'(px); e.py = 10'(py); e.hs = hs; e.vs = vs;
        e.von = von; e.col = col; e.fs = fs;
        return e;
    endfunction

    // Expected outputs n clocks after reset: k pixels have elapsed, the
    // registered outputs describe pixel k-1 of the raster.
    function automatic exp_t model(input int d, input int n, input logic [11:0] trgb);
        exp_t e;
        int   k, q, qh, qv;
        k = n / d;
        e = mk(k % SHT, (k / SHT) % SVT, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
        if (k > 0) begin
            q  = k - 1;
            qh = q % SHT;
            qv = (q / SHT) % SVT;
            e.von = (qh < SHA) && (qv < SVA);
            e.hs  = !((qh >= SHA + SHF) && (qh < SHA + SHF + SHS));
            e.vs  = !((qv >= SVA + SVF) && (qv < SVA + SVF + SVS));
            e.col = e.von ? trgb : 12'h000;
            e.fs  = ((n % d) == 0) && (qh == SHT - 1) && (qv == SVT - 1);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst_s) begin
            n3 <= 0; n1 <= 0; t3 <= 12'h000; t1 <= 12'h000;
        end else begin
            n3 <= n3 + 1;
            n1 <= n1 + 1;
            if (((n3 + 1) % 3) == 0) t3 <= rgb_s;
            t1 <= rgb_s;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic reset_d(input logic [11:0] col);
        rst_d = 1'b1;
        rgb_d = col;
        @(negedge clk);
        rst_d = 1'b0;
    endtask

    function automatic exp_t act_d();
        return {d_px, d_py, d_hs, d_vs, d_von, d_r, d_g, d_b, d_fs};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0,    12'hF3A, mk(0,   0, 1, 1, 0, 12'h000, 0)};
        tbl[1]  = '{3,    12'hF3A, mk(0,   0, 1, 1, 0, 12'h000, 0)};
        tbl[2]  = '{4,    12'hF3A, mk(1,   0, 1, 1, 1, 12'hF3A, 0)};
        tbl[3]  = '{2560, 12'h5A5, mk(640, 0, 1, 1, 1, 12'h5A5, 0)};
        tbl[4]  = '{2564, 12'h5A5, mk(641, 0, 1, 1, 0, 12'h000, 0)};
        tbl[5]  = '{2624, 12'hFFF, mk(656, 0, 1, 1, 0, 12'h000, 0)};
        tbl[6]  = '{2628, 12'hFFF, mk(657, 0, 0, 1, 0, 12'h000, 0)};
        tbl[7]  = '{2804, 12'hFFF, mk(701, 0, 0, 1, 0, 12'h000, 0)};
        tbl[8]  = '{3008, 12'hFFF, mk(752, 0, 0, 1, 0, 12'h000, 0)};
        tbl[9]  = '{3012, 12'hFFF, mk(753, 0, 1, 1, 0, 12'h000, 0)};
        tbl[10] = '{3200, 12'h7C1, mk(0,   1, 1, 1, 0, 12'h000, 0)};
        tbl[11] = '{3206, 12'h7C1, mk(1,   1, 1, 1, 1, 12'h7C1, 0)};

        @(negedge clk);

        // Table: reset, hold rgb, run n clocks, compare all outputs.
        for (int i = 0; i < 12; i++) begin
            reset_d(tbl[i].rgb);
            repeat (tbl[i].n) @(negedge clk);
            chk($sformatf("tbl[%0d] n=%0d", i, tbl[i].n), 64'(act_d()), 64'(tbl[i].e));
        end

        // One full line on the default raster: h_sync width/position, line length.
        reset_d(12'h0F0);
        hs_low = 0;
        first_low = -1;
        for (int i = 1; i <= 3200; i++) begin
            @(negedge clk);
            if (!d_hs) begin
                hs_low++;
                if (first_low < 0) first_low = i;
            end
            if (i == 3199) chk("line_px_799", 64'(d_px), 64'd799);
            if (i == 3200) chk("line_wrap_xy", 64'({d_px, d_py}), 64'({10'd0, 10'd1}));
        end
        chk("hsync_low_clks", 64'(hs_low), 64'd384);
        chk("hsync_first_low", 64'(first_low), 64'd2628);

        // Mid-frame reset between pixel ticks.
        reset_d(12'h123);
        repeat (4802) @(negedge clk);
        chk("pre_rst_xy", 64'({d_px, d_py}), 64'({10'd400, 10'd1}));
        rst_d = 1'b1;
        @(negedge clk);
        rst_d = 1'b0;
        chk("mid_rst_state", 64'(act_d()), 64'(mk(0, 0, 1, 1, 0, 12'h000, 0)));
        repeat (3) @(negedge clk);
        chk("post_rst_px_hold", 64'(act_d()), 64'(mk(0, 0, 1, 1, 0, 12'h000, 0)));
        @(negedge clk);
        chk("post_rst_first_pix", 64'(act_d()), 64'(mk(1, 0, 1, 1, 1, 12'h123, 0)));

        // CLK_DIV=1 shrunken raster: per-clock pixels, frame period, sync widths.
        rst_s = 1'b1;
        rgb_s = 12'hABC;
        @(negedge clk);
        rst_s = 1'b0;
        fs_cnt = 0; first_fs = -1; second_fs = -1; hs_low = 0; vs_low = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (i == 5) chk("s1_px_step5", 64'(s1_px), 64'd5);
            if (i == 6) chk("s1_px_step6", 64'(s1_px), 64'd6);
            if (s1_fs) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = i;
                else if (second_fs < 0) second_fs = i;
            end
            if (i <= SHT && !s1_hs) hs_low++;
            if (i <= SHT * SVT && !s1_vs) vs_low++;
        end
        chk("s1_fs_count", 64'(fs_cnt), 64'd2);
        chk("s1_first_fs", 64'(first_fs), 64'(SHT * SVT));
        chk("s1_frame_period", 64'(second_fs - first_fs), 64'(SHT * SVT));
        chk("s1_hsync_width", 64'(hs_low), 64'(SHS));
        chk("s1_vsync_width", 64'(vs_low), 64'(SVS * SHT));

        // Random colour and occasional resets against the raster model.
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            chk("s3_model", 64'({s3_px, s3_py, s3_hs, s3_vs, s3_von, s3_r, s3_g, s3_b, s3_fs}),
                64'(model(3, n3, t3)));
            chk("s1_model", 64'({s1_px, s1_py, s1_hs, s1_vs, s1_von, s1_r, s1_g, s1_b, s1_fs}),
                64'(model(1, n1, t1)));
            rgb_s = 12'($urandom);
            rst_s = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
